// File: rtl/frac_div_scheduler.sv
// -----------------------------------------------------------------------------
// frac_div_scheduler
//   Sequencing controller for a fractional clock divider. Each output period
//   is either N or N+1 input cycles long. A first-order NUM/DEN phase
//   accumulator chooses between them, so the long-run divide ratio is
//   N + NUM/DEN. New ratios arrive through a valid/ready port, wait in a
//   shadow slot and are applied only at period boundaries (or while idle),
//   so the divided clock never glitches.
//
// Ports
//   clk, rst          system clock, asynchronous active-low reset
//   enable            level-sensitive run request
//   cfg_valid/ready   config handshake; ready means the shadow slot is empty
//   cfg_int           integer divide N (must be >= 2)
//   cfg_num, cfg_den  fractional part; den = 0 selects a pure integer divide
//   cfg_err           one-cycle pulse when an offered config is rejected
//   div_clk           divided clock, high for the first floor(L/2) cycles
//   div_pulse         one-cycle pulse on the first cycle of every period
//   seg_long          current period is N+1 cycles long
//   busy              controller is not idle
//   period_cnt        completed periods since reset
//
// Optional feature macro: FRAC_DIV_PERIOD_CNT_EN
//   defined   -> period_cnt counts completed periods (wraps at 2^32)
//   undefined -> period_cnt is tied to zero and the counter is absent
// -----------------------------------------------------------------------------
module frac_div_scheduler #(
  parameter int CNT_W = 8,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_int,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             div_pulse,
  output logic             seg_long,
  output logic             busy,
  output logic [31:0]      period_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W:0]   LEN_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] INT_MIN  = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [CNT_W:0]   len_r, len_nx_s;
  logic [ACC_W-1:0] acc_r, acc_nx_s;

  logic [CNT_W-1:0] act_int_r;
  logic [ACC_W-1:0] act_num_r, act_den_r;
  logic             sh_full_r;
  logic [CNT_W-1:0] sh_int_r;
  logic [ACC_W-1:0] sh_num_r, sh_den_r;

  logic cfg_err_r, div_clk_r, div_pulse_r, seg_long_r, busy_r;

  logic             xfer_s, cfg_bad_s, boundary_s, apply_s, start_s;
  logic [CNT_W-1:0] eff_int_s;
  logic [ACC_W-1:0] eff_num_s, eff_den_s, eff_acc_s, acc_start_s;
  logic [ACC_W:0]   sum_s;
  logic             long_s, long_nx_s;
  logic [CNT_W:0]   len_start_s;
  logic             div_clk_nx_s, div_pulse_nx_s, seg_long_nx_s, busy_nx_s;

  // Config handshake decode: a transfer happens whenever the slot is empty.
  always_comb begin
    xfer_s    = cfg_valid & ~sh_full_r;
    cfg_bad_s = (cfg_int < INT_MIN) |
                ((cfg_den != ACC_ZERO) & (cfg_num >= cfg_den));
  end

  // Last cycle of a running period.
  always_comb begin
    boundary_s = (state_r == ST_RUN) && ({1'b0, cnt_r} == (len_r - LEN_ONE));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: state_nx_s = ST_RUN;
      ST_RUN: begin
        if (boundary_s && !enable) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Period-start arithmetic. The shadow only reaches the datapath through
  // apply_s, which looks at the registered slot, so a config accepted in a
  // boundary cycle waits for the following boundary.
  always_comb begin
    apply_s = sh_full_r & ((state_r != ST_RUN) | boundary_s);
    start_s = (state_r == ST_LOAD) | (boundary_s & enable);
    if (apply_s) begin
      eff_int_s = sh_int_r;
      eff_num_s = sh_num_r;
      eff_den_s = sh_den_r;
    end else begin
      eff_int_s = act_int_r;
      eff_num_s = act_num_r;
      eff_den_s = act_den_r;
    end
    if (apply_s || (state_r == ST_LOAD)) begin
      eff_acc_s = ACC_ZERO;
    end else begin
      eff_acc_s = acc_r;
    end
    // One extra bit so acc + NUM never wraps before the compare.
    sum_s  = {1'b0, eff_acc_s} + {1'b0, eff_num_s};
    long_s = (eff_den_s != ACC_ZERO) && (sum_s >= {1'b0, eff_den_s});
    if (eff_den_s == ACC_ZERO) begin
      acc_start_s = eff_acc_s;
    end else if (long_s) begin
      acc_start_s = ACC_W'(sum_s - {1'b0, eff_den_s});
    end else begin
      acc_start_s = ACC_W'(sum_s);
    end
    if (long_s) begin
      len_start_s = {1'b0, eff_int_s} + LEN_ONE;
    end else begin
      len_start_s = {1'b0, eff_int_s};
    end
  end

  // Counter, length and accumulator next values.
  always_comb begin
    cnt_nx_s  = cnt_r;
    len_nx_s  = len_r;
    acc_nx_s  = acc_r;
    long_nx_s = seg_long_r;
    if (start_s) begin
      cnt_nx_s  = CNT_ZERO;
      len_nx_s  = len_start_s;
      acc_nx_s  = acc_start_s;
      long_nx_s = long_s;
    end else if (state_nx_s == ST_RUN) begin
      cnt_nx_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nx_s  = CNT_ZERO;
      long_nx_s = 1'b0;
      if (apply_s) begin
        acc_nx_s = ACC_ZERO;
      end else begin
        acc_nx_s = acc_r;
      end
    end
  end

  // Output decode, computed from next-state values so the registered outputs
  // line up with the cycle they describe.
  always_comb begin
    busy_nx_s      = (state_nx_s != ST_IDLE);
    div_pulse_nx_s = start_s;
    div_clk_nx_s   = (state_nx_s == ST_RUN) &&
                     ({1'b0, cnt_nx_s} < {1'b0, len_nx_s[CNT_W:1]});
    if (state_nx_s == ST_RUN) begin
      seg_long_nx_s = long_nx_s;
    end else begin
      seg_long_nx_s = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= CNT_ZERO;
      len_r <= {(CNT_W+1){1'b0}};
      acc_r <= ACC_ZERO;
    end else begin
      cnt_r <= cnt_nx_s;
      len_r <= len_nx_s;
      acc_r <= acc_nx_s;
    end
  end

  // Shadow slot and active ratio.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_full_r <= 1'b0;
      sh_int_r  <= CNT_ZERO;
      sh_num_r  <= ACC_ZERO;
      sh_den_r  <= ACC_ZERO;
      act_int_r <= INT_MIN;
      act_num_r <= ACC_ZERO;
      act_den_r <= ACC_ZERO;
    end else begin
      if (apply_s) begin
        sh_full_r <= 1'b0;
        act_int_r <= sh_int_r;
        act_num_r <= sh_num_r;
        act_den_r <= sh_den_r;
      end else if (xfer_s && !cfg_bad_s) begin
        sh_full_r <= 1'b1;
        sh_int_r  <= cfg_int;
        sh_num_r  <= cfg_num;
        sh_den_r  <= cfg_den;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err_r   <= 1'b0;
      div_clk_r   <= 1'b0;
      div_pulse_r <= 1'b0;
      seg_long_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cfg_err_r   <= xfer_s & cfg_bad_s;
      div_clk_r   <= div_clk_nx_s;
      div_pulse_r <= div_pulse_nx_s;
      seg_long_r  <= seg_long_nx_s;
      busy_r      <= busy_nx_s;
    end
  end

  assign cfg_ready = ~sh_full_r;
  assign cfg_err   = cfg_err_r;
  assign div_clk   = div_clk_r;
  assign div_pulse = div_pulse_r;
  assign seg_long  = seg_long_r;
  assign busy      = busy_r;

`ifdef FRAC_DIV_PERIOD_CNT_EN
  logic [31:0] period_cnt_r;

  // Completed-period counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt_r <= 32'd0;
    end else if (boundary_s) begin
      period_cnt_r <= period_cnt_r + 32'd1;
    end else begin
      period_cnt_r <= period_cnt_r;
    end
  end

  assign period_cnt = period_cnt_r;
`else
  assign period_cnt = 32'd0;
`endif

endmodule
